// File: rtl/load_down_counter_pkg.sv
// Shared types for load_down_counter: FSM state encoding and reload-mode constants.
package load_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter, one-shot or periodic, with a registered terminal-count pulse.
// Latency: load is visible on count one cycle later; each en tick in RUN decrements by one the next cycle.
// Backpressure: none. en is a free-running tick. Optional sticky done output when LOAD_DOWN_COUNTER_STICKY_DONE_EN is defined.
module load_down_counter
    import load_down_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
`ifdef LOAD_DOWN_COUNTER_STICKY_DONE_EN
    output logic             done,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic             r_mode, w_mode_nxt;
    logic             r_tc, w_tc_nxt;
    logic             r_done, w_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= MODE_ONESHOT;
            r_tc     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_mode   <= w_mode_nxt;
            r_tc     <= w_tc_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Load beats en; the terminal step is taken only from count == 1, so count can never underflow.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_mode_nxt   = r_mode;
        w_tc_nxt     = 1'b0;
        w_done_nxt   = r_done;
        if (load) begin
            w_count_nxt  = load_val;
            w_reload_nxt = load_val;
            w_mode_nxt   = mode;
            w_done_nxt   = 1'b0;
            w_state_nxt  = (load_val != '0) ? RUN : IDLE;
        end else if (r_state == RUN && en) begin
            if (r_count > WIDTH'(1)) begin
                w_count_nxt = r_count - WIDTH'(1);
            end else if (r_count == WIDTH'(1)) begin
                w_tc_nxt   = 1'b1;
                w_done_nxt = 1'b1;
                if (r_mode == MODE_PERIODIC) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = DONE;
                end
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = (r_state == RUN);

`ifdef LOAD_DOWN_COUNTER_STICKY_DONE_EN
    assign done = r_done;
`else
    logic w_done_unused;
    assign w_done_unused = r_done;
`endif

endmodule

// File: tb/tb_load_down_counter.sv
// Directed bench for load_down_counter (WIDTH=4); sticky-done steps are built with LOAD_DOWN_COUNTER_STICKY_DONE_EN.
module tb_load_down_counter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst, en, load, mode;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc, busy;
`ifdef LOAD_DOWN_COUNTER_STICKY_DONE_EN
    logic             done;
`endif

    int total = 0;
    int bad   = 0;

    load_down_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
`ifdef LOAD_DOWN_COUNTER_STICKY_DONE_EN
        .done     (done),
`endif
        .count    (count),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input logic t, input logic b);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".tc"},    32'(tc),    32'(t));
        check({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    int exp_per [8] = '{3, 2, 1, 4, 3, 2, 1, 4};

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd5; mode = 1'b0;
        tick();
        check_all("reset_over_load", 0, 1'b0, 1'b0);
        rst = 1'b0; load = 1'b0; en = 1'b0;
        tick();
        check_all("reset_hold", 0, 1'b0, 1'b0);

        // One-shot from 3
        load = 1'b1; load_val = 4'd3; mode = 1'b0; en = 1'b1;
        tick();
        check_all("os_load", 3, 1'b0, 1'b1);
        load = 1'b0;
        tick(); check_all("os_2", 2, 1'b0, 1'b1);
        tick(); check_all("os_1", 1, 1'b0, 1'b1);
        tick(); check_all("os_0", 0, 1'b1, 1'b0);
        tick(); check_all("os_done_a", 0, 1'b0, 1'b0);
        tick(); check_all("os_done_b", 0, 1'b0, 1'b0);

        // Periodic reload 4
        load = 1'b1; load_val = 4'd4; mode = 1'b1;
        tick();
        check_all("per_load", 4, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_all($sformatf("per_%0d", i), exp_per[i], (i == 3 || i == 7), 1'b1);
        end

        // One-shot 15 with en toggling
        load = 1'b1; load_val = 4'd15; mode = 1'b0; en = 1'b0;
        tick();
        check_all("tog_load", 15, 1'b0, 1'b1);
        load = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            en = 1'b1;
            tick();
            check_all($sformatf("tog_en_%0d", k), 15 - k, (k == 15), (k != 15));
            en = 1'b0;
            tick();
            check_all($sformatf("tog_idle_%0d", k), 15 - k, 1'b0, (k != 15));
        end

        // Load priority over en mid-count
        load = 1'b1; load_val = 4'd15; mode = 1'b0; en = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check_all("prio_at7", 7, 1'b0, 1'b1);
        load = 1'b1; load_val = 4'd9;
        tick();
        check_all("prio_load9", 9, 1'b0, 1'b1);
        load = 1'b0;
        tick();
        check_all("prio_dec", 8, 1'b0, 1'b1);

        // Reset mid-count aborts without tc
        load = 1'b1; load_val = 4'd2; mode = 1'b0;
        tick();
        load = 1'b0;
        tick();
        check_all("abort_pre", 1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        check_all("abort_rst", 0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_all("abort_post", 0, 1'b0, 1'b0);

        // Load 0 goes idle
        load = 1'b1; load_val = 4'd0; mode = 1'b1;
        tick();
        check_all("zero_load", 0, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        check_all("zero_en", 0, 1'b0, 1'b0);

        // Periodic reload 1: tc every cycle
        load = 1'b1; load_val = 4'd1; mode = 1'b1;
        tick();
        check_all("p1_load", 1, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("p1_%0d", i), 1, 1'b1, 1'b1);
        end
        en = 1'b0;
        tick();
        check_all("p1_hold", 1, 1'b0, 1'b1);

`ifdef LOAD_DOWN_COUNTER_STICKY_DONE_EN
        load = 1'b1; load_val = 4'd2; mode = 1'b0; en = 1'b1;
        tick();
        check("sd_load", 32'(done), 32'd0);
        load = 1'b0;
        tick();
        check("sd_1", 32'(done), 32'd0);
        tick();
        check_all("sd_tc", 0, 1'b1, 1'b0);
        check("sd_rise", 32'(done), 32'd1);
        tick();
        check("sd_tc_low", 32'(tc), 32'd0);
        check("sd_sticky", 32'(done), 32'd1);
        load = 1'b1; load_val = 4'd3;
        tick();
        check("sd_clear", 32'(done), 32'd0);
        load = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_down_counter.md
LOAD_DOWN_COUNTER -- requirements
Module: load_down_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  count-enable tick; one decrement per cycle when high in RUN.
REQ-005 load  input  1  load strobe; captures load_val and mode.
REQ-006 load_val  input  WIDTH  start/reload value.
REQ-007 mode  input  1  0 = one-shot, 1 = periodic; sampled only with load.
REQ-008 count  output  WIDTH  current count, registered.
REQ-009 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-010 busy  output  1  high while state is RUN.

Function
REQ-011 States: IDLE, RUN, DONE; busy = (state == RUN), registered or decoded from state register only.
REQ-012 load in any state: count <= load_val, reload_reg <= load_val, mode_reg <= mode, tc <= 0; next state RUN if load_val != 0, else IDLE.
REQ-013 load has priority over en in the same cycle; no decrement on a load cycle.
REQ-014 RUN, en=1, count > 1: count <= count - 1, tc <= 0.
REQ-015 RUN, en=1, count == 1, mode_reg=0: count <= 0, tc <= 1, state -> DONE.
REQ-016 RUN, en=1, count == 1, mode_reg=1: count <= reload_reg, tc <= 1, state stays RUN; period = reload_reg en-ticks.
REQ-017 Periodic with reload_reg == 1: count holds 1, tc high on every cycle following an en=1 cycle.
REQ-018 RUN, en=0: count and state hold, tc <= 0.
REQ-019 IDLE and DONE: count holds, en ignored, tc <= 0 (except the DONE-entry pulse of REQ-015).
REQ-020 count never wraps below 0; no underflow path exists.
REQ-021 tc is never high for two consecutive cycles unless REQ-017 applies.

Reset
REQ-022 rst=1 at a clock edge: count=0, reload_reg=0, mode_reg=0, tc=0, state=IDLE, busy=0; rst overrides load and en.
REQ-023 rst asserted mid-count aborts the count with no tc pulse.

Configuration
REQ-024 Macro LOAD_DOWN_COUNTER_STICKY_DONE_EN defined: add output done (1 bit), set to 1 on the same edge tc rises, cleared by load or rst, reset value 0.
REQ-025 Macro undefined: no done port; all other behaviour identical.

Structure
REQ-026 Package load_down_counter_pkg holds the state enum (IDLE, RUN, DONE) and mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1).
REQ-027 No sub-module; state machine and datapath live in one module.

Verification
REQ-028 rst=1 one cycle with load=1, load_val=5 -> count=0, state IDLE, tc=0, busy=0.
REQ-029 WIDTH=4, load 3, mode=0, en=1 continuous -> count 3,2,1,0; tc=1 exactly in the cycle count becomes 0; busy falls same edge; further en leaves count=0.
REQ-030 load 4, mode=1, en=1 continuous -> count 4,3,2,1,4,3,...; tc pulses every 4 cycles, aligned with each reload to 4.
REQ-031 load 15 mode=0, toggle en 1/0 alternately -> count decrements only on en cycles; tc after 15 en-ticks; load 9 while count=7 with en=1 -> count=9, no decrement that cycle.
REQ-032 load 0 -> state IDLE, count 0, no tc; periodic load 1 with en=1 -> count stays 1, tc every cycle.
REQ-033 STICKY_DONE_EN build: one-shot load 2, en=1 -> done rises with tc, stays 1 after tc drops, clears on next load.
